display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
- Shares the single display path (BCD conversion, then 7-segment drive) among NUM_CLIENTS value sources.
- Picks one masked, valid client by round-robin and captures its value.
- Offers the captured value to the display controller with a valid/ready handshake.
- Holds the display for a configurable dwell time before the next grant.

Parameters:
- DATA_WIDTH, 8: width of each client value and of number_to_display.
- NUM_CLIENTS, 4: number of requesters (2..8).
- DWELL_W, 16: width of the dwell-cycle counter and of dwell_cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-high (1 = reset)
- client_data  input  NUM_CLIENTS*DATA_WIDTH  packed client values; client i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- client_valid  input  NUM_CLIENTS  client i has a value pending
- enable_mask  input  NUM_CLIENTS  1 = client eligible for grant
- dwell_cycles  input  DWELL_W  hold time after display acceptance
- ready  input  1  display controller can take a value
- client_ack  output  NUM_CLIENTS  one-hot, one-cycle pulse: value captured
- number_to_display  output  DATA_WIDTH  captured value
- client_number  output  $clog2(NUM_CLIENTS)  index of the granted client
- disp_valid  output  1  number_to_display valid for the display
- busy  output  1  state is not IDLE

Behaviour:
- Reset values (next edge with rst_n=1):
  - client_ack=0, number_to_display=0, client_number=0, disp_valid=0, busy=0.
  - State=IDLE; RR pointer=NUM_CLIENTS-1, so client 0 is searched first.
- Eligible vector = client_valid & enable_mask.
- IDLE:
  - If eligible is nonzero, the winner is the first set bit searching upward from pointer+1, wrapping modulo NUM_CLIENTS.
  - At the edge: capture client_data[winner] into number_to_display, winner into client_number, set pointer=winner, state→OFFER.
  - client_ack[winner]=1 for exactly the following cycle.
  - If eligible is zero, remain in IDLE.
- OFFER:
  - disp_valid=1; number_to_display and client_number held stable.
  - Transfer occurs on a cycle with disp_valid&&ready.
  - On transfer: disp_valid→0 next cycle; sample dwell_cycles.
    - If the sampled value is 0: state→IDLE.
    - Otherwise: counter=dwell_cycles, state→DWELL.
  - ready low means wait indefinitely; no timeout.
- DWELL: counter decrements each cycle; at counter==1 state→IDLE. No disp_valid. number_to_display keeps its last value.
- Latency: eligible in cycle N, client_ack and disp_valid both high in cycle N+1. Earliest next grant decision is the cycle after returning to IDLE.
- Boundaries:
  - client_valid or enable_mask changing during OFFER/DWELL does not affect the current grant.
  - A client that drops valid after capture does not affect the transfer.
  - Single eligible client: granted repeatedly, one grant per IDLE pass.
  - Pointer wrap: after a grant to NUM_CLIENTS-1, search starts at 0.
  - dwell_cycles is sampled only at transfer; later changes apply to the next grant.
  - Reset mid-OFFER/DWELL: outputs reach reset values at that edge; the pending value is dropped, with no extra client_ack.
  - enable_mask=0: never grants; busy stays 0.

Optional Feature:
- Macro: DISPLAY_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority replaces round-robin; the lowest-index eligible client always wins, and the pointer is unused (may be removed).
- Undefined: round-robin as above.
- Port list is identical in both builds.

Decomposition:
- Package display_sched_pkg holds:
  - enum sched_state_t {IDLE, OFFER, DWELL};
  - default constants for NUM_CLIENTS and DWELL_W;
  - function client_idx_w(n) = $clog2(n).
- Sub-module disp_rr_pick: combinational round-robin picker.
  - Inputs: eligible vector, pointer.
  - Outputs: found flag, winner index.
  - Under DISPLAY_SCHED_FIXED_PRIO_EN it implements the priority encoder.

Test Plan:
- Reset then all four valid, mask=4'hF, ready=1, dwell=0 → grants in order 0,1,2,3,0; client_ack one-hot each grant; disp_valid one cycle per grant.
- Only client 2 valid, data=8'd157, ready low 5 cycles → disp_valid held 5+ cycles with 157 / client_number=2 stable; released one cycle after ready=1.
- dwell_cycles=3 after transfer → busy for exactly 3 DWELL cycles, next client_ack no earlier than 5 cycles after transfer.
- mask=4'b1010 with all valid → only clients 1 and 3 granted, alternating; mask cleared mid-OFFER → current transfer still completes.
- rst_n=1 during OFFER → next cycle disp_valid=0, busy=0; after release, first grant goes to client 0.
- Build with DISPLAY_SCHED_FIXED_PRIO_EN, clients 1 and 3 continuously valid → client 1 granted every time.

Source files
------------

// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared state type, defaults and index-width helper for display_scheduler
package display_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    DWELL
  } sched_state_t;

  localparam int DEF_NUM_CLIENTS = 4;
  localparam int DEF_DWELL_W     = 16;

  function automatic int client_idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/disp_rr_pick.sv
// rtl/disp_rr_pick.sv - combinational client picker (round-robin, or fixed priority under DISPLAY_SCHED_FIXED_PRIO_EN)
module disp_rr_pick
  import display_sched_pkg::*;
#(
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] eligible,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   found,
  output logic [IDX_W-1:0]       winner
);

`ifdef DISPLAY_SCHED_FIXED_PRIO_EN

  // The pointer has no meaning when the lowest index always wins.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Lowest-index eligible client wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (!found && eligible[i]) begin
        found  = 1'b1;
        winner = IDX_W'(i);
      end
    end
  end

`else

  // Index of the client 'step' places after p, wrapping at NUM_CLIENTS.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int step);
    int s;
    s = int'(p) + step;
    if (s >= NUM_CLIENTS) s = s - NUM_CLIENTS;
    return s[IDX_W-1:0];
  endfunction

  // First eligible client after the pointer, the pointer itself searched last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      if (!found && eligible[wrap_idx(ptr, i)]) begin
        found  = 1'b1;
        winner = wrap_idx(ptr, i);
      end
    end
  end

`endif

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - shares one display path among clients; DISPLAY_SCHED_FIXED_PRIO_EN selects fixed priority
module display_scheduler
  import display_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
  parameter int DWELL_W     = DEF_DWELL_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_data,
  input  logic [NUM_CLIENTS-1:0]            client_valid,
  input  logic [NUM_CLIENTS-1:0]            enable_mask,
  input  logic [DWELL_W-1:0]                dwell_cycles,
  input  logic                              ready,
  output logic [NUM_CLIENTS-1:0]            client_ack,
  output logic [DATA_WIDTH-1:0]             number_to_display,
  output logic [$clog2(NUM_CLIENTS)-1:0]    client_number,
  output logic                              disp_valid,
  output logic                              busy
);

  localparam int IDX_W = client_idx_w(NUM_CLIENTS);

  sched_state_t           state;
  sched_state_t           state_nx;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       winner;
  logic                   found;
  logic                   grant;
  logic                   xfer;
  logic [DWELL_W-1:0]     dwell_cnt;
  logic [NUM_CLIENTS-1:0] eligible;

  assign eligible = client_valid & enable_mask;

  disp_rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .found    (found),
    .winner   (winner)
  );

  // State register; rst_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state plus grant/transfer strobes for the datapath.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant    = 1'b1;
          state_nx = OFFER;
        end
      end
      OFFER: begin
        if (ready) begin
          xfer     = 1'b1;
          state_nx = (dwell_cycles == '0) ? IDLE : DWELL;
        end
      end
      DWELL: begin
        if (dwell_cnt == DWELL_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture the winner on grant, and run the dwell counter after transfer.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr               <= IDX_W'(NUM_CLIENTS - 1);
      client_ack        <= '0;
      number_to_display <= '0;
      client_number     <= '0;
      dwell_cnt         <= '0;
    end else begin
      client_ack <= '0;
      if (grant) begin
        ptr               <= winner;
        client_number     <= winner;
        number_to_display <= client_data[winner*DATA_WIDTH +: DATA_WIDTH];
        client_ack        <= NUM_CLIENTS'(1) << winner;
      end
      if (xfer)                dwell_cnt <= dwell_cycles;
      else if (state == DWELL) dwell_cnt <= dwell_cnt - DWELL_W'(1);
    end
  end

  assign disp_valid = (state == OFFER);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - randomized and directed bench for display_scheduler against a behavioural model
module tb_display_scheduler;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int WW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC*DW-1:0] client_data;
  logic [NC-1:0] client_valid;
  logic [NC-1:0] enable_mask;
  logic [WW-1:0] dwell_cycles;
  logic          ready;
  logic [NC-1:0] client_ack;
  logic [DW-1:0] number_to_display;
  logic [1:0]    client_number;
  logic          disp_valid;
  logic          busy;

  always #5 clk = ~clk;

  display_scheduler #(
    .DATA_WIDTH  (DW),
    .NUM_CLIENTS (NC),
    .DWELL_W     (WW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .client_data       (client_data),
    .client_valid      (client_valid),
    .enable_mask       (enable_mask),
    .dwell_cycles      (dwell_cycles),
    .ready             (ready),
    .client_ack        (client_ack),
    .number_to_display (number_to_display),
    .client_number     (client_number),
    .disp_valid        (disp_valid),
    .busy              (busy)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting, 1 = value offered, 2 = holding for m_left cycles.
  int            m_mode = 0;
  int            m_left = 0;
  int            m_ptr  = NC - 1;
  int            m_num  = 0;
  logic [DW-1:0] m_val  = '0;
  logic [NC-1:0] m_ack  = '0;
  bit            m_live = 1'b0;
  int            cyc_n  = 0;

  always @(posedge clk) begin
    logic [NC-1:0] elig;
    int w;
    cyc_n++;
    m_ack = '0;
    if (rst_n === 1'b1) begin
      m_live = 1'b1;
      m_mode = 0;
      m_ptr  = NC - 1;
      m_num  = 0;
      m_val  = '0;
    end else if (m_live) begin
      case (m_mode)
        0: begin
          elig = client_valid & enable_mask;
          w    = -1;
`ifdef DISPLAY_SCHED_FIXED_PRIO_EN
          for (int k = NC - 1; k >= 0; k--) if (elig[k]) w = k;
`else
          for (int k = NC; k >= 1; k--) if (elig[(m_ptr + k) % NC]) w = (m_ptr + k) % NC;
`endif
          if (w >= 0) begin
            m_mode   = 1;
            m_ptr    = w;
            m_num    = w;
            m_val    = client_data[w*DW +: DW];
            m_ack[w] = 1'b1;
          end
        end
        1: begin
          if (ready) begin
            if (dwell_cycles == 0) m_mode = 0;
            else begin
              m_mode = 2;
              m_left = int'(dwell_cycles);
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      endcase
    end
  end

  int glog_idx[$];
  int glog_cyc[$];

  // Per-cycle comparison against the model, plus a log of observed grants.
  always @(negedge clk) begin
    if (m_live) begin
      chk("disp_valid", 32'(disp_valid), 32'(m_mode == 1));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      chk("client_ack", 32'(client_ack), 32'(m_ack));
      chk("client_number", 32'(client_number), m_num);
      chk("number_to_display", 32'(number_to_display), 32'(m_val));
      for (int i = 0; i < NC; i++) begin
        if (client_ack[i] === 1'b1) begin
          glog_idx.push_back(i);
          glog_cyc.push_back(cyc_n);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int log_at(input int i);
    return (i < glog_idx.size()) ? glog_idx[i] : -1;
  endfunction

  function automatic int gap_at(input int i);
    return (i + 1 < glog_cyc.size()) ? glog_cyc[i+1] - glog_cyc[i] : -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int exp1[5];
  int exp4[4];
  logic [NC*DW-1:0] seed_data;

  initial begin
`ifdef DISPLAY_SCHED_FIXED_PRIO_EN
    exp1 = '{0, 0, 0, 0, 0};
    exp4 = '{1, 1, 1, 1};
`else
    exp1 = '{0, 1, 2, 3, 0};
    exp4 = '{1, 3, 1, 3};
`endif
    rst_n        = 1'b1;
    client_data  = '0;
    client_valid = '0;
    enable_mask  = '0;
    dwell_cycles = '0;
    ready        = 1'b0;
    step(2);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_disp_valid", 32'(disp_valid), 0);
    chk("reset_ack", 32'(client_ack), 0);
    chk("reset_number", 32'(number_to_display), 0);

    // All clients valid, no dwell: one grant every two cycles.
    seed_data    = {8'd44, 8'd33, 8'd22, 8'd11};
    client_data  = seed_data;
    client_valid = 4'hF;
    enable_mask  = 4'hF;
    ready        = 1'b1;
    rst_n        = 1'b0;
    glog_idx.delete();
    glog_cyc.delete();
    step(10);
    chk("t1_count", 32'(glog_idx.size() >= 5), 1);
    for (int i = 0; i < 5; i++) chk("t1_order", log_at(i), exp1[i]);
    chk("t1_gap", gap_at(0), 2);

    // Single client held by ready low; client drops valid after capture.
    client_valid = '0;
    step(4);
    client_data[2*DW +: DW] = 8'd157;
    client_valid = 4'b0100;
    ready        = 1'b0;
    step(2);
    client_valid = '0;
    step(5);
    chk("t2_held_valid", 32'(disp_valid), 1);
    chk("t2_value", 32'(number_to_display), 157);
    chk("t2_client", 32'(client_number), 2);
    ready = 1'b1;
    step(1);
    chk("t2_released", 32'(disp_valid), 0);

    // Dwell of three cycles: acks spaced five cycles apart.
    client_valid = 4'b0001;
    dwell_cycles = 16'd3;
    glog_idx.delete();
    glog_cyc.delete();
    step(20);
    chk("t3_gap0", gap_at(0), 5);
    chk("t3_gap1", gap_at(1), 5);

    // Masked clients alternate; clearing the mask mid-offer keeps the transfer.
    client_valid = '0;
    dwell_cycles = '0;
    step(8);
    client_valid = 4'hF;
    enable_mask  = 4'b1010;
    glog_idx.delete();
    glog_cyc.delete();
    step(10);
    for (int i = 0; i < 4; i++) chk("t4_order", log_at(i), exp4[i]);
    ready = 1'b0;
    step(3);
    enable_mask = '0;
    step(2);
    chk("t4_still_offered", 32'(disp_valid), 1);
    ready = 1'b1;
    step(1);
    chk("t4_transferred", 32'(disp_valid), 0);
    glog_idx.delete();
    glog_cyc.delete();
    step(20);
    chk("t4_mask0_busy", 32'(busy), 0);
    chk("t4_mask0_grants", glog_idx.size(), 0);

    // Reset while a grant to client 2 is offered; pointer restarts at client 0.
    enable_mask  = 4'hF;
    client_valid = 4'b0100;
    ready        = 1'b0;
    step(3);
    chk("t5_pre_offer", 32'(disp_valid), 1);
    chk("t5_pre_client", 32'(client_number), 2);
    rst_n = 1'b1;
    step(1);
    chk("t5_rst_valid", 32'(disp_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    rst_n        = 1'b0;
    client_valid = 4'hF;
    ready        = 1'b1;
    glog_idx.delete();
    glog_cyc.delete();
    step(3);
    chk("t5_first_grant", log_at(0), 0);

    // Randomized traffic, including sporadic resets and dwell changes.
    for (int n = 0; n < 3000; n++) begin
      client_data  = {$urandom, $urandom};
      client_valid = NC'($urandom);
      enable_mask  = ($urandom_range(0, 3) == 0) ? NC'($urandom) : 4'hF;
      ready        = ($urandom_range(0, 9) < 7);
      dwell_cycles = WW'($urandom_range(0, 4));
      rst_n        = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst_n = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
